// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, operand width and FSM state type
//               for the ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with one-hot grant output.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    // r_ptr names the requester that wins when both are valid
    logic r_ptr;
    logic w_pick1;

    always_comb begin
        w_pick1 = i_valid1 & (~i_valid0 | r_ptr);
        o_grant = 2'b00;
        if (i_en && (i_valid0 || i_valid1)) begin
            o_grant = w_pick1 ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (o_grant != 2'b00) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb
// Description : Arbitrates two requesters onto one shared ALU and holds the
//               result until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arb
    import alu_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReq0Valid,
    input  logic              iReq1Valid,
    output logic              oReq0Ready,
    output logic              oReq1Ready,
    input  logic [OP_W-1:0]   iReq0OP,
    input  logic [OP_W-1:0]   iReq1OP,
    input  logic [DATA_W-1:0] iReq0A,
    input  logic [DATA_W-1:0] iReq0B,
    input  logic [DATA_W-1:0] iReq1A,
    input  logic [DATA_W-1:0] iReq1B,
    output logic [OP_W-1:0]   oAluOP,
    output logic [DATA_W-1:0] oAluA,
    output logic [DATA_W-1:0] oAluB,
    input  logic [DATA_W-1:0] iAluC,
    input  logic              iAluZero,
    input  logic              iAluRdy,
    output logic              oRspValid,
    input  logic              iRspReady,
    output logic [DATA_W-1:0] oRspC,
    output logic              oRspZero,
    output logic              oRspId
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic                r_id;
    logic [DATA_W-1:0]   r_rsp_c;
    logic                r_rsp_zero;
    logic                r_rsp_id;
    logic                w_accept;
    logic                w_arb_en;
    logic [1:0]          w_grant;
    logic                w_grant_any;

    // A new request may be taken while idle or while the held response leaves
    assign w_accept    = (r_state == ST_IDLE) || ((r_state == ST_RESP) && iRspReady);
    assign w_arb_en    = w_accept && !iRst;
    assign w_grant_any = |w_grant;

    rr_arb2 u_rr_arb2 (
        .clk      (iClk),
        .rst      (iRst),
        .i_valid0 (iReq0Valid),
        .i_valid1 (iReq1Valid),
        .i_en     (w_arb_en),
        .o_grant  (w_grant)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_grant_any) w_state_nxt = ST_EXEC;
            ST_EXEC: if (iAluRdy)     w_state_nxt = ST_RESP;
            ST_RESP: if (iRspReady)   w_state_nxt = w_grant_any ? ST_EXEC : ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_id       <= 1'b0;
            r_rsp_c    <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_alu_op <= w_grant[1] ? iReq1OP : iReq0OP;
                r_alu_a  <= w_grant[1] ? iReq1A  : iReq0A;
                r_alu_b  <= w_grant[1] ? iReq1B  : iReq0B;
                r_id     <= w_grant[1];
            end
            // Grants never occur in EXEC, so these two loads cannot collide
            if ((r_state == ST_EXEC) && iAluRdy) begin
                r_rsp_c    <= iAluC;
                r_rsp_zero <= iAluZero;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign oReq0Ready = w_grant[0];
    assign oReq1Ready = w_grant[1];
    assign oAluOP     = r_alu_op;
    assign oAluA      = r_alu_a;
    assign oAluB      = r_alu_b;
    assign oRspValid  = (r_state == ST_RESP);
    assign oRspC      = r_rsp_c;
    assign oRspZero   = r_rsp_zero;
    assign oRspId     = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arb
// Description : Self-checking bench for alu_arb against a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arb;
    import alu_pkg::*;

    logic        iClk;
    logic        iRst;
    logic        iReq0Valid, iReq1Valid;
    logic        oReq0Ready, oReq1Ready;
    logic [3:0]  iReq0OP, iReq1OP;
    logic [31:0] iReq0A, iReq0B, iReq1A, iReq1B;
    logic [3:0]  oAluOP;
    logic [31:0] oAluA, oAluB;
    logic [31:0] iAluC;
    logic        iAluZero;
    logic        iAluRdy;
    logic        oRspValid;
    logic        iRspReady;
    logic [31:0] oRspC;
    logic        oRspZero;
    logic        oRspId;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (post-edge view of what the block should hold)
    bit          m_busy, m_held, m_ptr, m_id, m_rz, m_rid, m_gnt0, m_gnt1;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_rc;

    alu_arb dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iReq0Valid (iReq0Valid),
        .iReq1Valid (iReq1Valid),
        .oReq0Ready (oReq0Ready),
        .oReq1Ready (oReq1Ready),
        .iReq0OP    (iReq0OP),
        .iReq1OP    (iReq1OP),
        .iReq0A     (iReq0A),
        .iReq0B     (iReq0B),
        .iReq1A     (iReq1A),
        .iReq1B     (iReq1B),
        .oAluOP     (oAluOP),
        .oAluA      (oAluA),
        .oAluB      (oAluB),
        .iAluC      (iAluC),
        .iAluZero   (iAluZero),
        .iAluRdy    (iAluRdy),
        .oRspValid  (oRspValid),
        .iRspReady  (iRspReady),
        .oRspC      (oRspC),
        .oRspZero   (oRspZero),
        .oRspId     (oRspId)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return {a[15:0], b[15:0]} ^ {28'd0, op};
        endcase
    endfunction

    // Stand-in ALU: returns its result combinationally from what it is driven
    always_comb begin
        iAluC    = alu_fn(oAluOP, oAluA, oAluB);
        iAluZero = (iAluC == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: compare DUT against the model at negedge, then advance the model
    task automatic cycle();
        bit take, win, gnt;
        logic [31:0] r;
        @(negedge iClk);
        take = !iRst && ((!m_busy && !m_held) || (m_held && iRspReady));
        win  = (iReq0Valid && iReq1Valid) ? m_ptr : iReq1Valid;
        gnt  = take && (iReq0Valid || iReq1Valid);
        chk("rdy0",      32'(oReq0Ready), 32'(gnt && !win));
        chk("rdy1",      32'(oReq1Ready), 32'(gnt && win));
        chk("rsp_valid", 32'(oRspValid),  32'(m_held));
        chk("alu_op",    32'(oAluOP),     32'(m_op));
        chk("alu_a",     oAluA,           m_a);
        chk("alu_b",     oAluB,           m_b);
        chk("rsp_c",     oRspC,           m_rc);
        chk("rsp_zero",  32'(oRspZero),   32'(m_rz));
        chk("rsp_id",    32'(oRspId),     32'(m_rid));
        m_gnt0 = gnt && !win;
        m_gnt1 = gnt && win;
        if (iRst) begin
            m_busy = 0; m_held = 0; m_ptr = 0; m_id = 0; m_rz = 0; m_rid = 0;
            m_op = '0; m_a = '0; m_b = '0; m_rc = '0;
        end else if (gnt) begin
            m_op   = win ? iReq1OP : iReq0OP;
            m_a    = win ? iReq1A  : iReq0A;
            m_b    = win ? iReq1B  : iReq0B;
            m_id   = win;
            m_ptr  = !win;
            m_busy = 1;
            m_held = 0;
        end else if (m_busy && iAluRdy) begin
            r      = alu_fn(m_op, m_a, m_b);
            m_rc   = r;
            m_rz   = (r == 32'd0);
            m_rid  = m_id;
            m_busy = 0;
            m_held = 1;
        end else if (m_held && iRspReady) begin
            m_held = 0;
        end
        @(posedge iClk);
        #1;
    endtask

    initial begin
        bit          exp_w;
        logic [31:0] ta, tb;

        iRst = 1; iReq0Valid = 0; iReq1Valid = 0; iAluRdy = 0; iRspReady = 0;
        iReq0OP = '0; iReq1OP = '0; iReq0A = '0; iReq0B = '0; iReq1A = '0; iReq1B = '0;
        m_busy = 0; m_held = 0; m_ptr = 0; m_id = 0; m_rz = 0; m_rid = 0;
        m_gnt0 = 0; m_gnt1 = 0; m_op = '0; m_a = '0; m_b = '0; m_rc = '0;
        #1;
        cycle();
        cycle();
        iRst = 0;

        // Single request, one-cycle ALU: response two cycles after the grant
        iReq0Valid = 1; iReq0OP = OP_ADD; iReq0A = 32'd5; iReq0B = 32'd7; iAluRdy = 1;
        #1 chk("t1_rdy0", 32'(oReq0Ready), 32'd1);
        cycle();
        iReq0Valid = 0;
        chk("t1_alu_a", oAluA, 32'd5);
        chk("t1_alu_b", oAluB, 32'd7);
        cycle();
        chk("t1_valid", 32'(oRspValid), 32'd1);
        chk("t1_c",     oRspC,          32'd12);
        chk("t1_id",    32'(oRspId),    32'd0);

        // Consumer stalls with requester 1 waiting
        iReq1Valid = 1; iReq1OP = OP_XOR; iReq1A = 32'hF0F0_0000; iReq1B = 32'h0FF0_1234;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_rdy1_stall", 32'(oReq1Ready), 32'd0);
            cycle();
            chk("t3_hold_c", oRspC, 32'd12);
        end
        iRspReady = 1;
        #1 chk("t3_grant", 32'(oReq1Ready), 32'd1);
        cycle();
        iReq1Valid = 0;
        cycle();
        cycle();

        // Both requesters always valid: grants alternate starting with 0
        iReq0Valid = 1; iReq1Valid = 1; iReq0OP = OP_OR; iReq1OP = OP_AND;
        iReq0A = $urandom; iReq0B = $urandom; iReq1A = $urandom; iReq1B = $urandom;
        exp_w = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (oReq0Ready || oReq1Ready) begin
                chk("t2_alt", 32'(oReq1Ready), 32'(exp_w));
                exp_w = !exp_w;
            end
            cycle();
        end
        iReq0Valid = 0; iReq1Valid = 0;
        repeat (3) cycle();

        // Slow ALU: operands held, subtraction of equal values gives zero
        iReq0Valid = 1; iReq0OP = OP_SUB; iReq0A = 32'd3; iReq0B = 32'd3; iAluRdy = 0;
        cycle();
        iReq0Valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_op", 32'(oAluOP), 32'd1);
            chk("t4_a",  oAluA,       32'd3);
            cycle();
        end
        iAluRdy = 1;
        cycle();
        chk("t4_valid", 32'(oRspValid), 32'd1);
        chk("t4_c",     oRspC,          32'd0);
        chk("t4_zero",  32'(oRspZero),  32'd1);
        cycle();

        // Reset mid-operation abandons it and re-favours requester 0
        iReq0Valid = 1; iReq0OP = OP_SLL; iReq0A = 32'h1234_5678; iReq0B = 32'd4; iAluRdy = 0;
        cycle();
        iReq0Valid = 0; iRst = 1; iReq1Valid = 1;
        #1 chk("t5_rst_rdy1", 32'(oReq1Ready), 32'd0);
        cycle();
        iRst = 0; iReq1Valid = 0;
        chk("t5_valid",  32'(oRspValid), 32'd0);
        chk("t5_alu_op", 32'(oAluOP),    32'd0);
        chk("t5_alu_a",  oAluA,          32'd0);
        chk("t5_rsp_c",  oRspC,          32'd0);
        iReq0Valid = 1; iReq1Valid = 1;
        #1 chk("t5_ptr", 32'(oReq0Ready), 32'd1);
        cycle();
        iReq0Valid = 0; iReq1Valid = 0; iAluRdy = 1;
        cycle();
        cycle();

        // Undefined opcode passes straight through
        ta = $urandom; tb = $urandom;
        iReq0Valid = 1; iReq0OP = 4'hC; iReq0A = ta; iReq0B = tb;
        cycle();
        iReq0Valid = 0;
        chk("t6_op", 32'(oAluOP), 32'hC);
        cycle();
        chk("t6_c", oRspC, alu_fn(4'hC, ta, tb));
        cycle();

        // Randomized traffic; requesters hold payload until the model grants them
        for (int i = 0; i < 600; i++) begin
            if (m_gnt0 || !iReq0Valid) begin
                iReq0Valid = 1'($urandom_range(0, 1));
                iReq0OP    = 4'($urandom_range(0, 15));
                iReq0A     = $urandom;
                iReq0B     = ($urandom_range(0, 3) == 0) ? iReq0A : $urandom;
            end
            if (m_gnt1 || !iReq1Valid) begin
                iReq1Valid = 1'($urandom_range(0, 1));
                iReq1OP    = 4'($urandom_range(0, 15));
                iReq1A     = $urandom;
                iReq1B     = ($urandom_range(0, 3) == 0) ? iReq1A : $urandom;
            end
            iAluRdy   = ($urandom_range(0, 3) != 0);
            iRspReady = ($urandom_range(0, 2) != 0);
            iRst      = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL expose iClk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 The block SHALL expose iRst, input, 1, reset, synchronous and active-high.
REQ-003 The block SHALL expose iReq0Valid/iReq1Valid, input, 1 each, requester 0/1 has an operation pending.
REQ-004 The block SHALL expose oReq0Ready/oReq1Ready, output, 1 each, requester 0/1 operation accepted this cycle.
REQ-005 The block SHALL expose iReq0OP/iReq1OP, input, 4 each, ALU opcode per requester.
REQ-006 The block SHALL expose iReq0A, iReq0B, iReq1A and iReq1B, input, 32 each, operands per requester.
REQ-007 The block SHALL expose oAluOP, output, 4, opcode driven to the shared ALU.
REQ-008 The block SHALL expose oAluA/oAluB, output, 32 each, operands driven to the shared ALU.
REQ-009 The block SHALL expose iAluC, input, 32, ALU result, and iAluZero, input, 1, ALU zero flag.
REQ-010 The block SHALL expose iAluRdy, input, 1, ALU result valid this cycle.
REQ-011 The block SHALL expose oRspValid, output, 1, response held.
REQ-012 The block SHALL expose iRspReady, input, 1, consumer accepts the response.
REQ-013 The block SHALL expose oRspC, output, 32, registered result; oRspZero, output, 1, registered zero flag; oRspId, output, 1, winning requester index.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-015 Accept condition: state==IDLE, or state==RESP with iRspReady=1.
REQ-016 When the accept condition holds and any requester is valid, the granted requester's oReqNReady SHALL be 1 combinationally; the other ready SHALL be 0.
REQ-017 When the accept condition does not hold, both ready outputs SHALL be 0.
REQ-018 On a grant the block SHALL register OP, A, B and the requester index into oAluOP, oAluA, oAluB and an internal id; the next state SHALL be EXEC.
REQ-019 Arbitration SHALL be two-way round-robin: if only one requester is valid, it wins; if both are valid, the requester selected by the priority pointer wins.
REQ-020 After every grant, the pointer SHALL point to the non-granted requester; without a grant, the pointer SHALL hold.
REQ-021 In EXEC, ALU outputs SHALL hold stable; if iAluRdy=1, the block SHALL capture iAluC, iAluZero and the id into oRspC, oRspZero and oRspId, and the next state SHALL be RESP; otherwise the state SHALL stay EXEC with no timeout.
REQ-022 In RESP, oRspValid SHALL be 1 and the response registers SHALL hold until iRspReady=1.
REQ-023 In RESP with iRspReady=1 and no valid requester, the next state SHALL be IDLE and oRspValid SHALL drop the next cycle.
REQ-024 In RESP with iRspReady=1 and a valid requester, the new request SHALL be granted in the same cycle and the next state SHALL be EXEC (back-to-back).
REQ-025 Latency from grant cycle N with iAluRdy=1 on first EXEC cycle SHALL be: oRspValid=1 at N+2; sustained throughput SHALL be one operation per 2 cycles.
REQ-026 Opcodes SHALL be forwarded unchanged, including 4'hA-4'hF; the block SHALL NOT decode or reject opcodes.
REQ-027 oRspValid SHALL be 0 in IDLE and EXEC.
REQ-028 A requester SHALL keep its valid and payload stable until it is granted; the block SHALL NOT require this for correctness of the other requester.

Reset
REQ-029 When iRst=1 at a clock edge, the state SHALL become IDLE, the pointer SHALL be 0 (favouring requester 0), and oAluOP, oAluA, oAluB, oRspC, oRspZero, oRspId and the internal id SHALL be 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation with no response; a requester valid during reset SHALL NOT be granted in that cycle.
REQ-031 Both ready outputs SHALL be 0 while iRst=1.

Structure
REQ-032 Shared package alu_pkg SHALL hold opcode constants (ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9), the FSM state typedef, and the operand width 32.
REQ-033 The two-way round-robin arbiter SHALL be a sub-module rr_arb2 (inputs: two valids, enable; outputs: one-hot grant; internal pointer).

Verification
REQ-034 Test 1: after reset, req0 only, OP=0, A=5, B=7, iAluRdy=1 -> oReq0Ready at N, oAluA=5, oAluB=7 at N+1, oRspValid=1 with oRspC=12, oRspId=0 at N+2.
REQ-035 Test 2: both requesters valid continuously, iRspReady=1, iAluRdy=1 -> grants alternate 0,1,0,1 every 2 cycles.
REQ-036 Test 3: iRspReady=0 for 5 cycles in RESP with req1 pending -> response stable, oReq1Ready=0; when iRspReady=1, req1 is granted in that same cycle.
REQ-037 Test 4: iAluRdy=0 for 3 EXEC cycles, OP=1, A=3, B=3 -> oAluOP/A/B stay stable; response oRspC=0, oRspZero=1.
REQ-038 Test 5: iRst=1 during EXEC -> next cycle IDLE, oRspValid=0, all registers 0, and the pointer favours requester 0.
REQ-039 Test 6: OP=4'hC forwarded -> oAluOP=4'hC; the response equals whatever the ALU returns.
